fastserial_rx_fifo: RTL and testbench

//  Byte FIFO between the FTDI fast-serial receiver and the Avalon-ST bytes-to-packets

---
 rtl/fastserial_rx_fifo.sv | 100 ++++++++++
 tb/tb_fastserial_rx_fifo.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/fastserial_rx_fifo.sv
// Byte FIFO from the FTDI fast-serial receiver to an Avalon-ST sink; first-word fall-through.
// Optional `RXFIFO_DROP_COUNT_EN adds a saturating dropped-byte counter on o_drop_count.
module fastserial_rx_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_W-1:0]     i_data,
  input  logic                  i_wr,
  output logic [DATA_W-1:0]     o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_overflow,
  input  logic                  i_clr_overflow
`ifdef RXFIFO_DROP_COUNT_EN
  ,
  output logic [7:0]            o_drop_count
`endif
);

  localparam logic [DEPTH_LOG2:0] DEPTH = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);

  logic [DATA_W-1:0]   mem_q [1 << DEPTH_LOG2];
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic                overflow_q, overflow_d;
  logic [DEPTH_LOG2:0] count;
  logic                full, empty, pop, push, drop;

  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == DEPTH);
  assign empty = (count == '0);
  assign pop   = !empty && i_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts that write.
  assign push  = i_wr && (!full || pop);
  assign drop  = i_wr && full && !pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (drop)
      overflow_d = 1'b1;
    else if (i_clr_overflow)
      overflow_d = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push && !i_reset) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= i_data;
  end

`ifdef RXFIFO_DROP_COUNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      if (i_clr_overflow)
        drop_cnt_d = 8'd1;
      else if (drop_cnt_q != '1)
        drop_cnt_d = drop_cnt_q + 8'd1;
    end else if (i_clr_overflow) begin
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) drop_cnt_q <= '0;
    else         drop_cnt_q <= drop_cnt_d;
  end

  assign o_drop_count = drop_cnt_q;
`endif

  assign o_data     = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  assign o_valid    = !empty;
  assign o_empty    = empty;
  assign o_full     = full;
  assign o_count    = count;
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_fastserial_rx_fifo.sv
// Bench for fastserial_rx_fifo: directed scenarios plus random traffic against a queue model.
module tb_fastserial_rx_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned DL    = 4;
  localparam int unsigned DEPTH = 16;

  logic            clk = 1'b0;
  logic            i_reset, i_wr, i_ready, i_clr_overflow;
  logic [DW-1:0]   i_data, o_data;
  logic            o_valid, o_empty, o_full, o_overflow;
  logic [DL:0]     o_count;
`ifdef RXFIFO_DROP_COUNT_EN
  logic [7:0]      o_drop_count;
`endif

  fastserial_rx_fifo #(.DATA_W(DW), .DEPTH_LOG2(DL)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_data(i_data), .i_wr(i_wr),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_count(o_count),
    .o_empty(o_empty), .o_full(o_full), .o_overflow(o_overflow),
    .i_clr_overflow(i_clr_overflow)
`ifdef RXFIFO_DROP_COUNT_EN
    , .o_drop_count(o_drop_count)
`endif
  );

  always #5 clk = ~clk;

  byte unsigned q[$];
  bit           ovf_m;
  int unsigned  drop_m;
  bit           chk_en = 1'b0;
  int unsigned  vectors = 0;
  int unsigned  miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, compare outputs with the model, then advance the model across the edge.
  task automatic cycle(input bit rst, input bit wr, input logic [7:0] d, input bit rdy, input bit clr);
    bit pop, acc, drop;
    i_reset = rst; i_wr = wr; i_data = d; i_ready = rdy; i_clr_overflow = clr;
    #1;
    if (chk_en) begin
      check("valid", o_valid, q.size() != 0);
      check("empty", o_empty, q.size() == 0);
      check("full", o_full, q.size() == DEPTH);
      check("count", o_count, q.size());
      check("overflow", o_overflow, ovf_m);
      if (q.size() != 0) check("data", o_data, q[0]);
`ifdef RXFIFO_DROP_COUNT_EN
      check("drop_count", o_drop_count, drop_m);
`endif
    end
    if (rst) begin
      q.delete(); ovf_m = 0; drop_m = 0; chk_en = 1;
    end else begin
      pop  = (q.size() != 0) && rdy;
      acc  = wr && (q.size() < DEPTH || pop);
      drop = wr && !acc;
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(d);
      if (drop) ovf_m = 1; else if (clr) ovf_m = 0;
      if (drop) drop_m = clr ? 1 : (drop_m < 255 ? drop_m + 1 : 255);
      else if (clr) drop_m = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) cycle(0, 0, 8'h00, 1, 0);
  endtask

  initial begin
    i_reset = 1; i_wr = 0; i_data = '0; i_ready = 0; i_clr_overflow = 0;
    @(posedge clk); #1;

    // Reset then three bytes with the sink ready
    cycle(1, 0, 8'h00, 0, 0);
    cycle(0, 1, 8'h41, 1, 0);
    cycle(0, 1, 8'h42, 1, 0);
    cycle(0, 1, 8'h43, 1, 0);
    drain(3);

    // Fill to full, one dropped byte, then drain
    cycle(1, 0, 8'h00, 0, 0);
    for (int unsigned k = 0; k < 16; k++) cycle(0, 1, 8'(k), 0, 0);
    cycle(0, 1, 8'hAA, 0, 0);
    check("ovf_after_drop", o_overflow, 1'b1);
    check("count_after_drop", o_count, 5'd16);
    drain(18);
    cycle(0, 0, 8'h00, 0, 1);

    // Full with simultaneous pop and write
    cycle(1, 0, 8'h00, 0, 0);
    for (int unsigned k = 0; k < 16; k++) cycle(0, 1, 8'(8'h20 + k), 0, 0);
    cycle(0, 1, 8'h55, 1, 0);
    check("count_full_pop", o_count, 5'd16);
    check("ovf_full_pop", o_overflow, 1'b0);
    drain(17);

    // Alternating ready across 40 bytes, pointers wrap
    for (int unsigned k = 0; k < 80; k++)
      cycle(0, (k % 2) == 0, 8'(8'h60 + k / 2), (k % 2) == 1, 0);
    drain(4);

    // Reset mid-burst with a coincident strobe
    for (int unsigned k = 0; k < 7; k++) cycle(0, 1, 8'(8'h70 + k), 0, 0);
    cycle(1, 1, 8'hEE, 0, 0);
    check("count_after_rst", o_count, 5'd0);
    check("valid_after_rst", o_valid, 1'b0);
    cycle(0, 1, 8'h99, 0, 0);
    check("first_after_rst", o_data, 8'h99);
    drain(2);

`ifdef RXFIFO_DROP_COUNT_EN
    for (int unsigned k = 0; k < 16; k++) cycle(0, 1, 8'(k), 0, 0);
    for (int unsigned k = 0; k < 300; k++) cycle(0, 1, 8'hCC, 0, 0);
    check("drop_sat", o_drop_count, 8'hFF);
    cycle(0, 0, 8'h00, 0, 1);
    check("drop_clr", o_drop_count, 8'h00);
    check("ovf_clr", o_overflow, 1'b0);
    drain(17);
`endif

    // Random traffic, including overflow clears racing drops
    for (int unsigned k = 0; k < 1500; k++)
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 6), 8'($urandom),
            ($urandom_range(0, 9) < 5), ($urandom_range(0, 19) == 0));
    drain(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
